// File: rtl/wish_unpack_pkg.sv
// Shared definitions for the wish_pack / wish_unpack width converters:
// endian selection and beat-to-slice mapping.
package wish_unpack_pkg;

  typedef enum logic {
    ENDIAN_BIG    = 1'b0,
    ENDIAN_LITTLE = 1'b1
  } endian_e;

  localparam int MIN_PACK = 2;

  // Which slice of the wide word is emitted as beat number beat_idx.
  function automatic int slice_of(input int beat_idx, input int num_pack, input bit little);
    return little ? beat_idx : (num_pack - 1 - beat_idx);
  endfunction

endpackage

// File: rtl/wish_word_slot.sv
// One buffered word: data, cycle tag and valid bit, with load and clear.
// Load wins over clear; clearing drops only the valid bit so outputs stay stable.
module wish_word_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int TGC_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic [TGC_WIDTH-1:0]  load_tgc,
  output logic [DATA_WIDTH-1:0] dat,
  output logic [TGC_WIDTH-1:0]  tgc,
  output logic                  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat   <= '0;
      tgc   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dat   <= load_dat;
      tgc   <= load_tgc;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wish_unpack.sv
// Wishbone-style splitter: one wide word in, NUM_PACK narrow beats out, two-entry
// buffer (cur + nxt) so beats run back to back; d_ack never reaches s_ack combinationally.
module wish_unpack
  import wish_unpack_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  output logic                           d_last_o
);

  localparam int  WORD_W = DATA_WIDTH * NUM_PACK;
  localparam int  IDX_W  = $clog2(NUM_PACK);
  localparam bit  LITTLE = (LITTLE_ENDIAN == ENDIAN_LITTLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PACK - 1);

  logic [WORD_W-1:0]    cur_dat, nxt_dat, cur_src_dat;
  logic [TGC_WIDTH-1:0] cur_tgc, nxt_tgc, cur_src_tgc;
  logic                 cur_valid, nxt_valid;
  logic [IDX_W-1:0]     idx;

  logic acc, beat, is_last, fin;
  logic cur_load, cur_clear, nxt_load, nxt_clear;

  // Stall depends only on registered state and reset, keeping d_ack out of s_ack.
  assign s_stall_o = nxt_valid | rst_i;
  assign acc       = s_stb_i & s_cyc_i & ~s_stall_o;
  assign s_ack_o   = acc;

  assign beat    = cur_valid & d_ack_i;
  assign is_last = (idx == IDX_LAST);
  assign fin     = beat & is_last;

  // acc implies nxt is empty, so an empty cur means the whole buffer is idle.
  assign cur_load    = (acc & ~cur_valid) | (fin & (nxt_valid | acc));
  assign cur_clear   = fin & ~nxt_valid & ~acc;
  assign cur_src_dat = nxt_valid ? nxt_dat : s_dat_i;
  assign cur_src_tgc = nxt_valid ? nxt_tgc : s_tgc_i;

  assign nxt_load  = acc & cur_valid & ~fin;
  assign nxt_clear = fin & nxt_valid;

  wish_word_slot #(
    .DATA_WIDTH (WORD_W),
    .TGC_WIDTH  (TGC_WIDTH)
  ) u_cur (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cur_load),
    .clear    (cur_clear),
    .load_dat (cur_src_dat),
    .load_tgc (cur_src_tgc),
    .dat      (cur_dat),
    .tgc      (cur_tgc),
    .valid    (cur_valid)
  );

  wish_word_slot #(
    .DATA_WIDTH (WORD_W),
    .TGC_WIDTH  (TGC_WIDTH)
  ) u_nxt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (nxt_load),
    .clear    (nxt_clear),
    .load_dat (s_dat_i),
    .load_tgc (s_tgc_i),
    .dat      (nxt_dat),
    .tgc      (nxt_tgc),
    .valid    (nxt_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx <= '0;
    end else if (cur_load) begin
      idx <= '0;
    end else if (beat) begin
      idx <= is_last ? '0 : idx + IDX_W'(1);
    end
  end

  always_comb begin
    d_dat_o = '0;
    for (int k = 0; k < NUM_PACK; k++) begin
      if (idx == IDX_W'(k)) begin
        d_dat_o = cur_dat[slice_of(k, NUM_PACK, LITTLE)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign d_stb_o  = cur_valid;
  assign d_cyc_o  = cur_valid;
  assign d_tgc_o  = cur_tgc;
  assign d_last_o = cur_valid & is_last;

endmodule

// File: tb/tb_wish_unpack.sv
// Bench for wish_unpack: LE and BE 4-beat instances on shared stimulus, plus a 3-beat instance.
// A queue of expected beats per instance predicts every output cycle by cycle.
module tb_wish_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stb, cyc, dack;
  logic [31:0] sdat;
  logic [1:0]  stgc;

  logic       a_sack, a_stall, a_stb, a_cyc, a_last;
  logic [7:0] a_dat;
  logic [1:0] a_tgc;
  logic       b_sack, b_stall, b_stb, b_cyc, b_last;
  logic [7:0] b_dat;
  logic [1:0] b_tgc;

  logic        c_stbi, c_cyci, c_dack;
  logic [23:0] c_sdat;
  logic [1:0]  c_stgc;
  logic        c_sack, c_stall, c_stb, c_cyc, c_last;
  logic [7:0]  c_dat;
  logic [1:0]  c_tgc;

  wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .s_stb_i(stb), .s_cyc_i(cyc), .s_ack_o(a_sack),
    .s_stall_o(a_stall), .s_dat_i(sdat), .s_tgc_i(stgc), .d_stb_o(a_stb),
    .d_cyc_o(a_cyc), .d_ack_i(dack), .d_dat_o(a_dat), .d_tgc_o(a_tgc), .d_last_o(a_last));

  wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .s_stb_i(stb), .s_cyc_i(cyc), .s_ack_o(b_sack),
    .s_stall_o(b_stall), .s_dat_i(sdat), .s_tgc_i(stgc), .d_stb_o(b_stb),
    .d_cyc_o(b_cyc), .d_ack_i(dack), .d_dat_o(b_dat), .d_tgc_o(b_tgc), .d_last_o(b_last));

  wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(3), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .s_stb_i(c_stbi), .s_cyc_i(c_cyci), .s_ack_o(c_sack),
    .s_stall_o(c_stall), .s_dat_i(c_sdat), .s_tgc_i(c_stgc), .d_stb_o(c_stb),
    .d_cyc_o(c_cyc), .d_ack_i(c_dack), .d_dat_o(c_dat), .d_tgc_o(c_tgc), .d_last_o(c_last));

  typedef struct {
    logic [7:0] dat;
    logic [1:0] tgc;
    logic       last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A word becomes np beats; beat k carries slice k (LE) or slice np-1-k (BE).
  task automatic push_word(inout beat_t q[$], input logic [31:0] w, input logic [1:0] t,
                           input int np, input bit le);
    beat_t b;
    for (int k = 0; k < np; k++) begin
      int s;
      s      = le ? k : np - 1 - k;
      b.dat  = 8'((w >> (8 * s)) & 32'hFF);
      b.tgc  = t;
      b.last = (k == np - 1);
      q.push_back(b);
    end
  endtask

  // Words held = ceil(remaining beats / np); a second held word means the source stalls.
  task automatic step_ab(input bit s, input bit c, input bit a, input logic [31:0] d,
                         input logic [1:0] t);
    bit exp_stall, exp_acc, exp_stb;
    @(negedge clk);
    stb = s; cyc = c; dack = a; sdat = d; stgc = t;
    #1;
    exp_stall = ((qa.size() + 3) / 4) >= 2;
    exp_acc   = s & c & ~exp_stall;
    exp_stb   = qa.size() > 0;
    chk("a_stall", a_stall, exp_stall);
    chk("a_ack",   a_sack,  exp_acc);
    chk("b_stall", b_stall, exp_stall);
    chk("b_ack",   b_sack,  exp_acc);
    chk("a_ack_stall_excl", a_sack & a_stall, 0);
    chk("a_stb", a_stb, exp_stb);
    chk("a_cyc", a_cyc, exp_stb);
    chk("b_stb", b_stb, exp_stb);
    chk("b_cyc", b_cyc, exp_stb);
    if (exp_stb) begin
      chk("a_dat",  a_dat,  qa[0].dat);
      chk("a_tgc",  a_tgc,  qa[0].tgc);
      chk("a_last", a_last, qa[0].last);
      chk("b_dat",  b_dat,  qb[0].dat);
      chk("b_tgc",  b_tgc,  qb[0].tgc);
      chk("b_last", b_last, qb[0].last);
    end else begin
      chk("a_last_idle", a_last, 0);
      chk("b_last_idle", b_last, 0);
    end
    @(posedge clk);
    if (exp_stb && a) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (exp_acc) begin
      push_word(qa, d, t, 4, 1'b1);
      push_word(qb, d, t, 4, 1'b0);
    end
  endtask

  task automatic step_c(input bit s, input bit c, input bit a, input logic [23:0] d,
                        input logic [1:0] t);
    bit exp_stall, exp_acc, exp_stb;
    @(negedge clk);
    c_stbi = s; c_cyci = c; c_dack = a; c_sdat = d; c_stgc = t;
    #1;
    exp_stall = ((qc.size() + 2) / 3) >= 2;
    exp_acc   = s & c & ~exp_stall;
    exp_stb   = qc.size() > 0;
    chk("c_stall", c_stall, exp_stall);
    chk("c_ack",   c_sack,  exp_acc);
    chk("c_stb",   c_stb,   exp_stb);
    chk("c_cyc",   c_cyc,   exp_stb);
    if (exp_stb) begin
      chk("c_dat",  c_dat,  qc[0].dat);
      chk("c_tgc",  c_tgc,  qc[0].tgc);
      chk("c_last", c_last, qc[0].last);
    end else begin
      chk("c_last_idle", c_last, 0);
    end
    @(posedge clk);
    if (exp_stb && a) void'(qc.pop_front());
    if (exp_acc) push_word(qc, {8'h00, d}, t, 3, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    stb = 1'b1; cyc = 1'b1; dack = 1'b0; sdat = '0; stgc = '0;
    c_stbi = 1'b1; c_cyci = 1'b1; c_dack = 1'b0; c_sdat = '0; c_stgc = '0;
    #2;
    chk("rst_a_stall", a_stall, 1);
    chk("rst_a_ack",   a_sack,  0);
    chk("rst_a_stb",   a_stb,   0);
    chk("rst_a_dat",   a_dat,   0);
    chk("rst_c_stall", c_stall, 1);
    @(negedge clk);
    stb = 1'b0; c_stbi = 1'b0;
    #1 rst = 1'b0;

    // Single word, LE and BE views, full-rate acks.
    step_ab(1, 1, 1, 32'hDDCCBBAA, 2'b10);
    #1;
    chk("t1_first_le", a_dat, 8'hAA);
    chk("t2_first_be", b_dat, 8'hDD);
    for (int i = 0; i < 5; i++) step_ab(0, 0, 1, 32'h0, 2'b00);

    // Two words back to back.
    step_ab(1, 1, 1, 32'h04030201, 2'b01);
    step_ab(1, 1, 1, 32'h08070605, 2'b11);
    for (int i = 0; i < 8; i++) step_ab(1, 1, 1, 32'hEEEEEEEE, 2'b00);
    for (int i = 0; i < 10; i++) step_ab(0, 1, 1, 32'h0, 2'b00);

    // Destination holds off on beat BB while a second and third word arrive.
    step_ab(1, 1, 1, 32'hDDCCBBAA, 2'b01);
    step_ab(0, 0, 1, 32'h0, 2'b00);
    step_ab(1, 1, 0, 32'h55443322, 2'b10);
    #1 chk("t4_hold_bb", a_dat, 8'hBB);
    step_ab(1, 1, 0, 32'h99887766, 2'b11);
    #1 chk("t4_third_stalled", a_stall, 1);
    step_ab(1, 1, 0, 32'h99887766, 2'b11);
    for (int i = 0; i < 12; i++) step_ab(1, 1, 1, 32'h99887766, 2'b11);
    for (int i = 0; i < 8; i++) step_ab(0, 0, 1, 32'h0, 2'b00);

    // Strobe without cycle must not be accepted.
    step_ab(1, 0, 1, 32'h12345678, 2'b01);
    step_ab(0, 0, 1, 32'h0, 2'b00);

    // Asynchronous reset mid-burst after two beats.
    step_ab(1, 1, 1, 32'hA3A2A1A0, 2'b01);
    step_ab(1, 1, 1, 32'hB3B2B1B0, 2'b10);
    step_ab(0, 0, 1, 32'h0, 2'b00);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_stb",   a_stb,   0);
    chk("t5_rst_stall", a_stall, 1);
    chk("t5_rst_ack",   a_sack,  0);
    chk("t5_rst_b_stb", b_stb,   0);
    #1 rst = 1'b0;
    stb = 1'b0;
    qa.delete();
    qb.delete();
    step_ab(1, 1, 1, 32'h44332211, 2'b00);
    #1 chk("t5_first_after_rst", a_dat, 8'h11);
    for (int i = 0; i < 5; i++) step_ab(0, 0, 1, 32'h0, 2'b00);

    // Randomised traffic on the 4-beat pair.
    for (int i = 0; i < 400; i++)
      step_ab($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0, $urandom, 2'($urandom));
    for (int i = 0; i < 12; i++) step_ab(0, 0, 1, 32'h0, 2'b00);

    // 3-beat instance: index wraps 2 -> 0 into the following word.
    step_c(1, 1, 1, 24'h332211, 2'b01);
    #1 chk("t6_first", c_dat, 8'h11);
    step_c(1, 1, 1, 24'h665544, 2'b10);
    for (int i = 0; i < 6; i++) step_c(0, 0, 1, 24'h0, 2'b00);
    for (int i = 0; i < 300; i++)
      step_c($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 2) != 0, 24'($urandom), 2'($urandom));
    for (int i = 0; i < 10; i++) step_c(0, 0, 1, 24'h0, 2'b00);
    #1 chk("c_drained", c_stb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
